// File: rtl/decoder24_pkg.sv
// Shared constants for the 4-to-2 line code, used by both the encoder and decoder sides.
package decoder24_pkg;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

    localparam int IDX_A = 3;
    localparam int IDX_B = 2;
    localparam int IDX_C = 1;
    localparam int IDX_D = 0;

    // Every 2-bit code is legal, so the result is always exactly one-hot.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] line;
        line = 4'b0000;
        case (code)
            CODE_A:  line[IDX_A] = 1'b1;
            CODE_B:  line[IDX_B] = 1'b1;
            CODE_C:  line[IDX_C] = 1'b1;
            default: line[IDX_D] = 1'b1;
        endcase
        return line;
    endfunction

endpackage

// File: rtl/decoder24_stream_fifo2.sv
// Two-entry, 4-bit valid/ready FIFO. The in_ready output is registered, so no
// combinational path runs from out_ready to in_ready.
module fifo2_onehot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data
);

    logic [3:0] r_mem [2];
    logic       r_wrPtr;
    logic       r_rdPtr;
    logic [1:0] r_count;
    logic       r_inReady;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_countNext;

    always_comb begin
        w_push      = in_valid && r_inReady;
        w_pop       = (r_count != 2'd0) && out_ready;
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 2'd1;
            2'b01:   w_countNext = r_count - 2'd1;
            default: w_countNext = r_count;
        endcase
    end

    // in_ready is loaded from the next occupancy, so it reads "occupancy < 2" for the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]  <= 4'b0000;
            r_mem[1]  <= 4'b0000;
            r_wrPtr   <= 1'b0;
            r_rdPtr   <= 1'b0;
            r_count   <= 2'd0;
            r_inReady <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= in_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count   <= w_countNext;
            r_inReady <= (w_countNext < 2'd2);
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_mem[r_rdPtr] : 4'b0000;

endmodule

// File: rtl/decoder24_stream.sv
// Streaming 2-to-4 line decoder: decodes {x,y} into a one-hot line, buffers it in a
// 2-entry FIFO and keeps saturating per-line occurrence counters for link statistics.
module decoder24_stream
    import decoder24_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_x,
    input  logic             in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_line,
    input  logic             clr_cnt,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value,
    output logic [3:0]       cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       w_decoded;
    logic             w_outHs;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_sat;

    assign w_decoded = decode({in_x, in_y});

    fifo2_onehot u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_decoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_line)
    );

    assign w_outHs = out_valid && out_ready;

    // Counters stop at the maximum value; a clear in the same cycle beats a counted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_sat <= 4'b0000;
        end else if (clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_sat <= 4'b0000;
        end else if (w_outHs) begin
            for (int i = 0; i < 4; i++) begin
                if (out_line[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    if (r_cnt[i] == (CNT_MAX - CNT_ONE)) begin
                        r_sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign cnt_value = r_cnt[cnt_sel];
    assign cnt_sat   = r_sat;

endmodule

// File: doc/decoder24_stream.md
Name: decoder24_stream

Overview:
- Receiving end of the 4-to-2 encoded line code: accepts a stream of 2-bit codes {x,y} and regenerates the one-hot line {a,b,c,d}.
- Input and output use a valid/ready handshake; a 2-entry output buffer absorbs downstream stalls.
- Per-line saturating occurrence counters support link statistics and debug readback.
- Sits directly after the encoded link, or after a register slice on it, and feeds the one-hot consumer.

Parameters:
- CNT_W, 8, width of each per-line occurrence counter (legal range 2..16).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a code is presented on in_x/in_y.
- in_ready  output  1  block can accept a code this cycle.
- in_x  input  1  encoded bit x.
- in_y  input  1  encoded bit y.
- out_valid  output  1  out_line holds a decoded value.
- out_ready  input  1  downstream accepts out_line this cycle.
- out_line  output  4  one-hot output, bit order {a,b,c,d} (bit3=a ... bit0=d).
- clr_cnt  input  1  synchronous clear of all counters and saturation flags.
- cnt_sel  input  2  counter select for readback: 3=a, 2=b, 1=c, 0=d.
- cnt_value  output  CNT_W  combinational readback of the selected counter.
- cnt_sat  output  4  sticky per-line saturation flags, same bit order as out_line.

Behaviour:
- Code map (inverse of the encoder):
  - {x,y}=11 -> 4'b1000 (a)
  - 10 -> 4'b0100 (b)
  - 01 -> 4'b0010 (c)
  - 00 -> 4'b0001 (d)
- All four codes are legal; the output is always exactly one-hot.
- Reset (rst_n low, asynchronous):
  - FIFO empty; out_valid=0, out_line=4'b0000, in_ready=0 while rst_n is low.
  - All counters 0; cnt_sat=4'b0000.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Input accept: in_valid && in_ready at a rising edge; the decoded one-hot value is written into the FIFO.
- Latency:
  - An accepted code into an empty FIFO appears with out_valid=1 on the next cycle (1-cycle latency).
  - No combinational path from in_* to out_*.
- FIFO:
  - Depth 2, in-order.
  - out_line/out_valid always show the head entry.
  - out_line is 4'b0000 whenever out_valid=0.
- in_ready:
  - Registered; equals "occupancy < 2" as of the start of the cycle.
  - Does not depend combinationally on out_ready.
- Simultaneous push and pop:
  - Occupancy 1: stays 1, and the new entry becomes head on the next cycle.
  - Occupancy 2: no push is possible (in_ready=0), so the pop frees one slot and in_ready=1 next cycle.
- Empty FIFO: out_valid=0, and out_ready is ignored.
- Stability: while out_valid=1 and out_ready=0, out_line holds stable.
- Counters:
  - On each output handshake (out_valid && out_ready), the counter of the line set in out_line increments by 1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - The matching cnt_sat bit sets on the increment that reaches the maximum and stays set until clr_cnt or reset.
- clr_cnt:
  - Zeroes all counters and all cnt_sat bits at the next edge.
  - If an output handshake occurs in the same cycle, clear wins and that event is not counted.
  - Does not affect the FIFO or the handshakes.
- Reset mid-transfer: buffered codes are discarded; nothing is replayed after reset.

Decomposition:
- Shared package decoder24_pkg holds:
  - code constants CODE_A=2'b11, CODE_B=2'b10, CODE_C=2'b01, CODE_D=2'b00;
  - one-hot bit indices IDX_A=3 .. IDX_D=0;
  - a decode function from a 2-bit code to 4-bit one-hot.
  - The encoder side imports the same constants.
- One sub-module, fifo2_onehot: 2-entry, 4-bit-wide valid/ready FIFO with registered in_ready.
- Counters and readback mux stay in the top module.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_line=0000, in_ready=0 during reset and 1 after the first edge, cnt_value=0 for all cnt_sel.
- Streaming: send codes 00,01,10,11 back-to-back with out_ready=1 -> out_line sequence 0001,0010,0100,1000, each one cycle after acceptance. Then cnt_value=1 for each cnt_sel.
- Backpressure: with out_ready=0, offer three codes 11,10,01 -> first two accepted, in_ready=0 on the third. out_line holds 1000. Raise out_ready -> outputs 1000,0100,0010 in order, with no loss or duplication.
- Simultaneous push/pop at occupancy 1: stream continuously with out_ready=1 -> sustained 1 transfer per cycle, occupancy never exceeds 1.
- Saturation, CNT_W=2: issue 5 handshakes of code 01 -> cnt_sel=1 reads 3, and cnt_sat=0010 from the third handshake onward.
- Clear race: assert clr_cnt in the same cycle as a code-00 output handshake -> all counters 0, cnt_sat=0000. A later code-00 handshake makes cnt_sel=0 read 1.
